// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch-offset forms, with a
// two-entry skid buffer (main + skid) so in_ready comes straight from a flop.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);
    // State encoding doubles as the valid bits: {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [1:0]       mode;
    } entry_t;

    state_t state_q, state_n;
    entry_t main_q, skid_q, new_e;
    logic   load_main, load_skid, skid_to_main, accept;

    logic signed [IN_W-1:0]  imm_s;
    logic        [OUT_W-1:0] sx, zx, ext;

    assign imm_s = in_imm;
    assign sx    = OUT_W'(imm_s);   // signed cast sign-extends
    assign zx    = OUT_W'(in_imm);

    // Select the extension form; branch shift cannot overflow since OUT_W >= IN_W+SHAMT.
    always_comb begin
        ext = sx;
        case (in_mode)
            2'b00:   ext = sx;
            2'b01:   ext = zx;
            2'b10:   ext = zx << (OUT_W - IN_W);
            default: ext = sx << SHAMT;
        endcase
    end

    assign new_e     = '{data: ext, mode: in_mode};
    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q.data;
    assign out_mode  = main_q.mode;
    assign accept    = in_valid & in_ready;

    // Next state and register-load controls.
    always_comb begin
        state_n      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (out_ready) begin
                    // Draining main; a same-cycle accept replaces it.
                    if (accept) load_main = 1'b1;
                    else        state_n   = EMPTY;
                end else if (accept) begin
                    state_n   = TWO;
                    load_skid = 1'b1;
                end
            end
            TWO: begin
                // in_ready is low here, so nothing new arrives.
                if (out_ready) begin
                    state_n      = ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // State register; reset flushes both entries asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_n;
    end

    // Entry payload registers; main holds its value whenever not loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)         main_q <= new_e;
            else if (skid_to_main) main_q <= skid_q;
            if (load_skid)         skid_q <= new_e;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default and narrow parameter variants.
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, out_mode;
    logic [31:0] out_data;

    logic        v2, r2, ov2, or2;
    logic [11:0] imm2;
    logic [1:0]  mode2, om2;
    logic [15:0] od2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .SHAMT(1)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(v2), .in_ready(r2), .in_imm(imm2), .in_mode(mode2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_mode(om2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] imm, input logic [1:0] m);
        case (m)
            2'd0:    return {{16{imm[15]}}, imm};
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    task automatic push(input logic [15:0] imm, input logic [1:0] m);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = m;
        tick();
    endtask

    initial begin
        logic [15:0] ri;
        logic [1:0]  rm;
        reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        v2 = 1'b0; imm2 = '0; mode2 = '0; or2 = 1'b1;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_mode",  out_mode,  0);
        chk("rst_in_ready",  in_ready,  1);
        reset = 1'b0;
        tick();

        // Basic modes, out_ready high, one-cycle latency.
        out_ready = 1'b1;
        push(16'h8001, 2'd0);
        chk("sign_valid", out_valid, 1);
        chk("sign_data",  out_data,  32'hFFFF8001);
        chk("sign_mode",  out_mode,  0);
        push(16'h8001, 2'd1);
        chk("zero_data",  out_data,  32'h00008001);
        chk("zero_mode",  out_mode,  1);
        push(16'h1234, 2'd2);
        chk("upper_data", out_data,  32'h12340000);
        push(16'hFFFF, 2'd3);
        chk("br_neg",     out_data,  32'hFFFFFFFC);
        push(16'h7FFF, 2'd3);
        chk("br_pos",     out_data,  32'h0001FFFC);
        chk("br_mode",    out_mode,  3);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", out_valid, 0);

        // Backpressure: A, B accepted, C held while stalled.
        out_ready = 1'b0;
        push(16'd1, 2'd1);
        chk("bp_a_data",  out_data, 1);
        chk("bp_a_ready", in_ready, 1);
        push(16'd2, 2'd1);
        chk("bp_b_ready", in_ready, 0);
        chk("bp_b_data",  out_data, 1);
        push(16'd3, 2'd1);
        chk("bp_c_held",  in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable_data",  out_data,  1);
            chk("bp_stable_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_out2_valid", out_valid, 1);
        chk("bp_out2_data",  out_data,  2);
        chk("bp_ready_back", in_ready,  1);
        tick();
        chk("bp_out3_valid", out_valid, 1);
        chk("bp_out3_data",  out_data,  3);
        in_valid = 1'b0;
        tick();
        chk("bp_done", out_valid, 0);

        // Streaming: 100 random back-to-back items.
        for (int i = 0; i < 100; i++) begin
            ri = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            chk("st_in_ready", in_ready, 1);
            push(ri, rm);
            chk("st_valid", out_valid, 1);
            chk("st_data",  out_data,  ref16(ri, rm));
            chk("st_mode",  out_mode,  rm);
        end
        in_valid = 1'b0;
        tick();
        chk("st_done", out_valid, 0);

        // Reset while in TWO, asserted between edges.
        out_ready = 1'b0;
        push(16'd5, 2'd1);
        push(16'd6, 2'd1);
        chk("rm_two", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_valid", out_valid, 0);
        chk("rm_data",  out_data,  0);
        chk("rm_ready", in_ready,  1);
        in_valid = 1'b1; in_imm = 16'd7;
        tick();
        chk("rm_discard", out_valid, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        push(16'd9, 2'd1);
        chk("rm_next_valid", out_valid, 1);
        chk("rm_next_data",  out_data,  9);
        in_valid = 1'b0;
        tick();
        chk("rm_alone", out_valid, 0);

        // Narrow variant IN_W=12, OUT_W=16, SHAMT=1.
        v2 = 1'b1; imm2 = 12'h800; mode2 = 2'd3;
        tick();
        chk("p2_br",    od2, 16'hF000);
        chk("p2_valid", ov2, 1);
        mode2 = 2'd2;
        tick();
        chk("p2_upper", od2, 16'h8000);
        mode2 = 2'd0;
        tick();
        chk("p2_sign",  od2, 16'hF800);
        mode2 = 2'd1;
        tick();
        chk("p2_zero",  od2, 16'h0800);
        v2 = 1'b0;
        tick();
        chk("p2_done",  ov2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the datapath. Replaces the fixed 16-to-32 sign extender.
- Accepts an IN_W-bit immediate plus a mode, and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-load, and branch-offset (sign-extend then shift).
- Sits between decode and execute with a valid/ready handshake on both sides.
- A two-entry skid buffer gives full throughput and registered backpressure.

Parameters:
- IN_W, 16, immediate input width; must be >= 2.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + SHAMT.
- SHAMT, 2, left-shift amount applied in branch-offset mode; must be >= 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents imm/mode.
- in_ready  output  1  unit can accept; transfer occurs when in_valid && in_ready at a clk edge.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready at a clk edge.
- out_data  output  OUT_W  extended result.
- out_mode  output  2  mode that produced out_data, for downstream muxing and debug.

Behaviour:
Interface facts:
- One clock; reset is asynchronous and active-high.
- clk and reset are the names used.

Arithmetic (combinational on in_imm, registered on accept):
- Mode 00: in_imm[IN_W-1] replicated into the upper OUT_W-IN_W bits.
- Mode 01: upper OUT_W-IN_W bits are zero.
- Mode 10: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W]; lower bits zero. This is the LUI form.
- Mode 11: sign-extended value shifted left by SHAMT; vacated LSBs are zero. No overflow is possible given the parameter constraint.

Storage:
- Two registers: main (drives out_*) and skid.
- Each register holds data, mode and a valid bit.

State machine, encoded by {skid_valid, main_valid}:
- EMPTY: accept -> ONE.
- ONE with out_ready=1: accept -> ONE (new data into main); no accept -> EMPTY.
- ONE with out_ready=0: accept -> TWO (new data into skid); no accept -> ONE (hold).
- TWO with out_ready=1: skid moves to main -> ONE.
- TWO with out_ready=0: hold.
- TWO with out_ready=1 and in_valid=1: no accept, because in_ready is 0 in TWO.

Ready and latency:
- in_ready = !skid_valid, taken directly from a register. There is no combinational path from out_ready to in_ready.
- Latency: data accepted at edge N is visible on out_data after edge N (available in cycle N+1) when main is free.
- Throughput: 1 per cycle when out_ready is held high.

Ordering and stability:
- Strict FIFO order; no item is dropped or duplicated.
- out_data and out_mode must stay stable while out_valid=1 and out_ready=0.

Reset:
- main_valid=0, skid_valid=0, out_valid=0, out_data=0, out_mode=0, in_ready=1.
- Any transfer attempted while reset is asserted is discarded.
- Reset mid-operation flushes both entries immediately (asynchronously).

Simultaneous events:
- Accept and drain in the same cycle in ONE: the new item replaces main. out_valid stays 1 and the old item counts as delivered.
- Skid drain and new accept cannot coincide, because in_ready is 0 in TWO.

Test Plan:
1. Defaults, out_ready=1, in_imm=16'h8001 in mode 00 -> out_data=32'hFFFF8001 one cycle later; mode 01 -> 32'h00008001.
2. Mode 10 with in_imm=16'h1234 -> 32'h12340000. Mode 11 with in_imm=16'hFFFF -> 32'hFFFFFFFC. Mode 11 with 16'h7FFF -> 32'h0001FFFC.
3. Backpressure: out_ready=0, then offer A=1, B=2, C=3 on consecutive cycles (mode 01):
   - A and B are accepted; in_ready falls after B; C is held.
   - Release out_ready -> outputs 1, 2, 3 in order; no gaps after the release.
   - out_data stays stable at 1 throughout the stall.
4. Streaming: out_ready=1 with 100 back-to-back random imm/mode items -> 100 outputs, all matching the reference model, in_ready constantly 1.
5. Reset mid-operation in state TWO (asserted between edges) -> out_valid=0, out_data=0, in_ready=1 immediately. After deassert, the next item is delivered alone.
6. Parameter variant IN_W=12, OUT_W=16, SHAMT=1: in_imm=12'h800 in mode 11 -> 16'hF000; mode 10 -> 16'h8000.
